// File: rtl/line_tracker_pkg.sv
// Shared encodings and defaults for the line-following robot controller.
package line_tracker_pkg;

  typedef enum logic [2:0] {
    MODE_STOP  = 3'b000,
    MODE_FWD   = 3'b001,
    MODE_LEFT  = 3'b011,
    MODE_RIGHT = 3'b110
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TRACK = 3'd1,
    ST_LOST  = 3'd2,
    ST_HALT  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam logic [15:0] DEBOUNCE_CYCLES_DEF = 16'd50000;
  localparam logic [31:0] LOST_TIMEOUT_DEF    = 32'd50_000_000;

  // Steering decision for a debounced {left, centre, right} pattern; no line yields STOP.
  function automatic mode_t track_mode(input logic [2:0] s);
    case (s)
      3'b010, 3'b111, 3'b101: track_mode = MODE_FWD;
      3'b100, 3'b110:         track_mode = MODE_LEFT;
      3'b001, 3'b011:         track_mode = MODE_RIGHT;
      default:                track_mode = MODE_STOP;
    endcase
  endfunction

endpackage

// File: rtl/line_tracker_fsm_debounce.sv
// One sensor bit: 2-flop synchronizer followed by a consecutive-difference debounce counter.
module sensor_debounce
  import line_tracker_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic        sync1_r;
  logic        sync2_r;
  logic        deb_r;
  logic [15:0] cnt_r;
  logic        settle_s;

  // The change is accepted on the cycle that completes DEBOUNCE_CYCLES differing samples.
  assign settle_s = ({1'b0, cnt_r} + 17'd1) >= {1'b0, DEBOUNCE_CYCLES};

  // Synchronize, then count consecutive samples that disagree with the debounced value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      deb_r   <= 1'b0;
      cnt_r   <= 16'd0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      if (sync2_r == deb_r) begin
        cnt_r <= 16'd0;
      end else if (settle_s) begin
        deb_r <= sync2_r;
        cnt_r <= 16'd0;
      end else if (cnt_r != 16'hFFFF) begin
        cnt_r <= cnt_r + 16'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign dout = deb_r;

endmodule

// File: rtl/line_tracker_fsm.sv
// Line-following controller: debounced IR sensors steer the motor stage,
// with lost-line search, timeout halt, obstacle hold and enable gating.
module line_tracker_fsm
  import line_tracker_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic [31:0] LOST_TIMEOUT    = LOST_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] sensor,
  input  logic       obstacle,
  output logic [2:0] mode,
  output logic [2:0] state_dbg
);

  logic [2:0]  line_s;
  logic        obs_sync1_r;
  logic        obs_sync2_r;
  state_t      state_r;
  mode_t       mode_r;
  mode_t       last_dir_r;
  logic [31:0] lost_cnt_r;
  logic        timeout_s;
  logic        line_seen_s;
  mode_t       track_s;

  for (genvar i = 0; i < 3; i++) begin : g_deb
    sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .din  (sensor[i]),
      .dout (line_s[i])
    );
  end

  // Obstacle is only synchronized; it acts as a stop request, so no debounce delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      obs_sync1_r <= 1'b0;
      obs_sync2_r <= 1'b0;
    end else begin
      obs_sync1_r <= obstacle;
      obs_sync2_r <= obs_sync1_r;
    end
  end

  assign timeout_s   = ({1'b0, lost_cnt_r} + 33'd1) >= {1'b0, LOST_TIMEOUT};
  assign line_seen_s = (line_s != 3'b000);
  assign track_s     = track_mode(line_s);

  // Controller FSM; mode is registered alongside the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      mode_r     <= MODE_STOP;
      last_dir_r <= MODE_LEFT;
      lost_cnt_r <= 32'd0;
    end else if (!enable) begin
      state_r    <= ST_IDLE;
      mode_r     <= MODE_STOP;
      lost_cnt_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r    <= ST_TRACK;
          mode_r     <= MODE_STOP;
          lost_cnt_r <= 32'd0;
        end
        ST_TRACK: begin
          lost_cnt_r <= 32'd0;
          if (obs_sync2_r) begin
            state_r <= ST_HOLD;
            mode_r  <= MODE_STOP;
          end else if (!line_seen_s) begin
            state_r <= ST_LOST;
            mode_r  <= last_dir_r;
          end else begin
            mode_r <= track_s;
            if (track_s == MODE_LEFT || track_s == MODE_RIGHT) last_dir_r <= track_s;
          end
        end
        ST_LOST: begin
          if (obs_sync2_r) begin
            state_r    <= ST_HOLD;
            mode_r     <= MODE_STOP;
            lost_cnt_r <= 32'd0;
          end else if (line_seen_s) begin
            // Reacquisition wins over a timeout landing on the same cycle.
            state_r    <= ST_TRACK;
            mode_r     <= track_s;
            lost_cnt_r <= 32'd0;
            if (track_s == MODE_LEFT || track_s == MODE_RIGHT) last_dir_r <= track_s;
          end else if (timeout_s) begin
            state_r    <= ST_HALT;
            mode_r     <= MODE_STOP;
            lost_cnt_r <= 32'd0;
          end else begin
            mode_r     <= last_dir_r;
            lost_cnt_r <= (lost_cnt_r == 32'hFFFF_FFFF) ? lost_cnt_r : lost_cnt_r + 32'd1;
          end
        end
        ST_HALT: begin
          lost_cnt_r <= 32'd0;
          if (obs_sync2_r) begin
            state_r <= ST_HOLD;
            mode_r  <= MODE_STOP;
          end else if (line_seen_s) begin
            state_r <= ST_TRACK;
            mode_r  <= track_s;
            if (track_s == MODE_LEFT || track_s == MODE_RIGHT) last_dir_r <= track_s;
          end else begin
            mode_r <= MODE_STOP;
          end
        end
        ST_HOLD: begin
          lost_cnt_r <= 32'd0;
          if (!obs_sync2_r) begin
            state_r <= ST_TRACK;
            mode_r  <= track_s;
            if (track_s == MODE_LEFT || track_s == MODE_RIGHT) last_dir_r <= track_s;
          end else begin
            mode_r <= MODE_STOP;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          mode_r     <= MODE_STOP;
          lost_cnt_r <= 32'd0;
        end
      endcase
    end
  end

  assign mode      = mode_r;
  assign state_dbg = state_r;

endmodule
